// File: rtl/debug_stepper_pkg.sv
// Shared definitions for the debug stepper:
// state encodings, debounce defaults, output decode.
package debug_stepper_pkg;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HALT = 2'd1,
    DBG_STEP = 2'd2,
    DBG_GAP  = 2'd3
  } dbg_state_e;

  localparam int unsigned DBG_DEBOUNCE_SIM   = 16;
  localparam int unsigned DBG_DEBOUNCE_BOARD = 100000;

  typedef struct packed {
    logic debug_en;
    logic debug_step;
    logic halted;
  } dbg_out_t;

  function automatic dbg_out_t dbg_decode(
    input dbg_state_e s
  );
    dbg_out_t o;
    o.debug_en   = (s != DBG_RUN);
    o.debug_step = (s == DBG_STEP);
    o.halted     = (s == DBG_HALT);
    return o;
  endfunction

endpackage

// File: rtl/debug_stepper_debounce.sv
// Button conditioner: 2-FF sync, stability
// counter, registered one-cycle rise pulse.
module debug_stepper_debounce #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // Synchronizer chain for the raw pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after it has held
  // for CYCLES consecutive cycles.
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d  = s2_q;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Filter state and registered edge output.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/debug_stepper.sv
// Debug halt/step driver for the pipeline
// controller: halt level plus clean step pulses.
module debug_stepper
  import debug_stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DBG_DEBOUNCE_SIM,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_debug,
  input  logic             btn_step,
  input  logic [CNT_W-1:0] run_count,
  input  logic             run_load,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_if,
  input  logic             if_valid,
  output logic             debug_en,
  output logic             debug_step,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] steps_left,
  output logic [31:0]      step_count
);

  logic sw_s1_q, sw_s_q, sw_d_q;
  logic sw_rise;
  logic step_req;
  logic hold;
  logic bp_match;

  dbg_state_e       state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             bp_q, bp_d;
  logic             arm_q;
  dbg_out_t         out_q, out_d;

  debug_stepper_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_step),
    .rise (step_req)
  );

  // Switch synchronizer plus one delay stage
  // for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= 1'b0;
      sw_s_q  <= 1'b0;
      sw_d_q  <= 1'b0;
    end else begin
      sw_s1_q <= sw_debug;
      sw_s_q  <= sw_s1_q;
      sw_d_q  <= sw_s_q;
    end
  end

  assign sw_rise  = sw_s_q & ~sw_d_q;
  assign hold     = sw_s_q | bp_q;
  assign bp_match = bp_en & if_valid
                  & (pc_if == bp_addr);

  // Next state, burst counters and sticky
  // breakpoint flag.
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    bp_d    = bp_q;
    if (sw_rise) begin
      bp_d = 1'b0;
    end
    unique case (state_q)
      DBG_RUN: begin
        if (hold) begin
          state_d = DBG_HALT;
        end else if (bp_match && arm_q) begin
          bp_d    = 1'b1;
          state_d = DBG_HALT;
        end
      end
      DBG_HALT: begin
        if (!hold) begin
          state_d = DBG_RUN;
        end else if (run_load && run_count != '0) begin
          steps_d = run_count;
          state_d = DBG_STEP;
        end else if (step_req) begin
          steps_d = CNT_W'(1);
          state_d = DBG_STEP;
        end
      end
      DBG_STEP: begin
        cnt_d   = cnt_q + 32'd1;
        steps_d = steps_q - CNT_W'(1);
        state_d = DBG_GAP;
      end
      DBG_GAP: begin
        if (steps_q != '0) begin
          state_d = DBG_STEP;
        end else if (!hold) begin
          state_d = DBG_RUN;
        end else begin
          state_d = DBG_HALT;
        end
      end
      default: state_d = DBG_RUN;
    endcase
  end

  assign out_d = dbg_decode(state_d);

  // State and output registers; arm lags RUN
  // by one cycle so a stalled IF PC cannot
  // re-trigger right after resuming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DBG_RUN;
      steps_q <= '0;
      cnt_q   <= '0;
      bp_q    <= 1'b0;
      arm_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      bp_q    <= bp_d;
      arm_q   <= (state_q == DBG_RUN);
      out_q   <= out_d;
    end
  end

  assign debug_en   = out_q.debug_en;
  assign debug_step = out_q.debug_step;
  assign halted     = out_q.halted;
  assign bp_hit     = bp_q;
  assign steps_left = steps_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_debug_stepper.sv
// Directed bench for debug_stepper: halt,
// debounce, bursts, breakpoint, reset.
module tb_debug_stepper;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             sw_debug;
  logic             btn_step;
  logic [CNT_W-1:0] run_count;
  logic             run_load;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc_if;
  logic             if_valid;
  logic             debug_en;
  logic             debug_step;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] steps_left;
  logic [31:0]      step_count;

  int nvec = 0;
  int nerr = 0;

  debug_stepper #(
    .DEBOUNCE_CYCLES (16),
    .CNT_W           (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_debug   (sw_debug),
    .btn_step   (btn_step),
    .run_count  (run_count),
    .run_load   (run_load),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_if      (pc_if),
    .if_valid   (if_valid),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .steps_left (steps_left),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic count_steps(
    input  int ncyc,
    output int n
  );
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (debug_step) n++;
    end
  endtask

  task automatic wait_n(input int ncyc);
    for (int i = 0; i < ncyc; i++)
      @(negedge clk);
  endtask

  initial begin
    int         n;
    logic [5:0] pat;
    logic       seen;

    rst       = 1'b1;
    sw_debug  = 1'b0;
    btn_step  = 1'b0;
    run_count = '0;
    run_load  = 1'b0;
    bp_en     = 1'b0;
    bp_addr   = 32'h20;
    pc_if     = 32'h0;
    if_valid  = 1'b0;

    wait_n(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_en",    {31'd0, debug_en},   0);
    chk("rst_step",  {31'd0, debug_step}, 0);
    chk("rst_halt",  {31'd0, halted},     0);
    chk("rst_bp",    {31'd0, bp_hit},     0);
    chk("rst_left",  {16'd0, steps_left}, 0);
    chk("rst_count", step_count,          0);

    sw_debug = 1'b1;
    wait_n(2);
    chk("sw_lat2", {31'd0, debug_en}, 0);
    @(negedge clk);
    chk("sw_lat3", {31'd0, debug_en}, 1);
    chk("sw_halt", {31'd0, halted},   1);

    btn_step = 1'b1;
    count_steps(20, n);
    begin
      int m;
      btn_step = 1'b0;
      count_steps(30, m);
      n += m;
    end
    chk("press_pulses", n,             1);
    chk("press_count",  step_count,    1);
    chk("press_halt", {31'd0, halted}, 1);

    n = 0;
    for (int g = 0; g < 6; g++) begin
      int m;
      btn_step = 1'b1;
      count_steps(5, m);
      n += m;
      btn_step = 1'b0;
      count_steps(5, m);
      n += m;
    end
    begin
      int m;
      count_steps(20, m);
      n += m;
    end
    chk("bounce_pulses", n,          0);
    chk("bounce_count",  step_count, 1);

    run_count = 16'd0;
    run_load  = 1'b1;
    @(negedge clk);
    run_load = 1'b0;
    count_steps(6, n);
    chk("zero_pulses", n,              0);
    chk("zero_halt", {31'd0, halted},  1);

    run_count = 16'd3;
    run_load  = 1'b1;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_load = 1'b0;
      pat = {pat[4:0], debug_step};
      if (i == 0)
        chk("burst_left3",
            {16'd0, steps_left}, 3);
    end
    chk("burst_pat",   {26'd0, pat}, 6'b101010);
    chk("burst_left0", {16'd0, steps_left}, 0);
    chk("burst_count", step_count, 4);
    @(negedge clk);
    chk("burst_halt", {31'd0, halted}, 1);

    sw_debug = 1'b0;
    wait_n(5);
    chk("resume_run", {31'd0, debug_en}, 0);

    bp_en    = 1'b1;
    bp_addr  = 32'h20;
    if_valid = 1'b1;
    pc_if    = 32'h20;
    @(negedge clk);
    chk("bp_hit",    {31'd0, bp_hit},   1);
    chk("bp_en_out", {31'd0, debug_en}, 1);
    wait_n(3);
    chk("bp_sticky", {31'd0, bp_hit},   1);

    sw_debug = 1'b1;
    wait_n(5);
    chk("bp_clear",  {31'd0, bp_hit},   0);
    chk("bp_held",   {31'd0, debug_en}, 1);
    sw_debug = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!debug_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_resume", {31'd0, seen}, 1);
    @(negedge clk);
    pc_if = 32'h24;
    wait_n(3);
    chk("bp_norearm", {31'd0, bp_hit},   0);
    chk("bp_running", {31'd0, debug_en}, 0);
    bp_en = 1'b0;

    sw_debug = 1'b1;
    wait_n(5);
    chk("mid_halt", {31'd0, halted}, 1);
    run_count = 16'd4;
    run_load  = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (debug_step) n++;
      if (i == 1) run_load = 1'b0;
      if (i == 2) sw_debug = 1'b0;
    end
    chk("mid_pulses", n,                  4);
    chk("mid_run",    {31'd0, debug_en},  0);
    chk("mid_count",  step_count,         8);

    sw_debug = 1'b1;
    wait_n(5);
    run_count = 16'd5;
    run_load  = 1'b1;
    @(negedge clk);
    run_load = 1'b0;
    wait_n(2);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_en",    {31'd0, debug_en},   0);
    chk("mrst_step",  {31'd0, debug_step}, 0);
    chk("mrst_halt",  {31'd0, halted},     0);
    chk("mrst_left",  {16'd0, steps_left}, 0);
    chk("mrst_count", step_count,          0);
    rst      = 1'b0;
    sw_debug = 1'b0;
    wait_n(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
